// File: rtl/cfg_arb_pkg.sv
// Shared types and constants for the configuration write arbiter.
package cfg_arb_pkg;

  // Commit FSM: IDLE (nothing staged), PENDING (staged, waiting for a
  // period boundary), COMMIT (single cycle copying staging to active).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } commit_state_e;

  localparam int unsigned NUM_REGS_DEFAULT = 5;

  // Register map of the configuration bank.
  localparam int unsigned REG_OUT_EN_LO = 0;
  localparam int unsigned REG_OUT_EN_HI = 1;
  localparam int unsigned REG_PWM_EN_LO = 2;
  localparam int unsigned REG_PWM_EN_HI = 3;
  localparam int unsigned REG_PWM_DUTY  = 4;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/cfg_write_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Holds which requester was served last and
// favours the other one when both request. The history only moves when the
// caller reports an actual transfer through 'advance'.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 = requester 1 was served last; reset value lets requester 0 win first.
  logic last_q, last_d;

  // Grant selection: single requester wins outright, contention alternates.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // History update only when a granted request actually transferred.
  always_comb begin
    last_d = last_q;
    if (advance) last_d = grant[1];
  end

  // History register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/cfg_write_arbiter.sv
// Configuration write arbiter: two write requesters share the config bank.
// Build option CFG_ARB_SHADOW_EN: when defined, writes land in a staging bank
// that is copied to the active bank on a commit_tick boundary; when undefined,
// accepted writes go straight to the active bank and commit_tick is ignored.
//
// Handshake (both requesters): a transfer happens on a rising edge where
// sN_valid && sN_ready; the requester keeps valid/addr/data stable until then.
// sN_ready is combinational, at most one requester is ready per cycle, and
// neither is ready during the single COMMIT cycle.
module cfg_write_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s0_valid,
  input  logic [ADDR_W-1:0]          s0_addr,
  input  logic [DATA_W-1:0]          s0_data,
  output logic                       s0_ready,
  input  logic                       s1_valid,
  input  logic [ADDR_W-1:0]          s1_addr,
  input  logic [DATA_W-1:0]          s1_data,
  output logic                       s1_ready,
  input  logic                       commit_tick,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic                       busy,
  output logic                       wr_err,
  output logic [7:0]                 err_cnt,
  output logic [1:0]                 dbg_state
);

  logic [1:0]                      req, grant;
  logic                            stall, xfer, in_range, wr_ok, wr_bad;
  logic [ADDR_W-1:0]               wr_addr;
  logic [DATA_W-1:0]               wr_data;
  logic [NUM_REGS-1:0][DATA_W-1:0] active_q, active_d;
  logic                            wr_err_q;
  logic [7:0]                      err_cnt_q, err_cnt_d;

  assign req = {s1_valid, s0_valid};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (xfer),
    .grant   (grant)
  );

  assign s0_ready = grant[0] & ~stall;
  assign s1_ready = grant[1] & ~stall;
  assign xfer     = (s0_valid & s0_ready) | (s1_valid & s1_ready);
  assign wr_addr  = grant[1] ? s1_addr : s0_addr;
  assign wr_data  = grant[1] ? s1_data : s0_data;
  assign in_range = 32'(wr_addr) < NUM_REGS;
  // Out-of-range writes are still acknowledged so a requester never hangs.
  assign wr_ok    = xfer & in_range;
  assign wr_bad   = xfer & ~in_range;

  // Saturating count of discarded out-of-range writes.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (wr_bad && err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error pulse, error count and active bank registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q  <= 1'b0;
      err_cnt_q <= 8'd0;
      active_q  <= '0;
    end else begin
      wr_err_q  <= wr_bad;
      err_cnt_q <= err_cnt_d;
      active_q  <= active_d;
    end
  end

  assign reg_out = active_q;
  assign wr_err  = wr_err_q;
  assign err_cnt = err_cnt_q;

`ifdef CFG_ARB_SHADOW_EN

  commit_state_e                   state_q, state_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] stage_q, stage_d;
  logic                            dirty_q, dirty_d;
  logic                            busy_q, busy_d;

  assign stall = (state_q == COMMIT);

  // Commit FSM next state; a tick while IDLE or COMMIT is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dirty_d) state_d = PENDING;
      PENDING: if (commit_tick) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Staging writes, dirty tracking and the atomic staging-to-active copy.
  // A write in the tick cycle lands in staging before COMMIT copies it.
  always_comb begin
    stage_d  = stage_q;
    dirty_d  = dirty_q;
    active_d = active_q;
    if (state_q == COMMIT) begin
      active_d = stage_q;
      dirty_d  = 1'b0;
    end else if (wr_ok) begin
      dirty_d = 1'b1;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_addr == ADDR_W'(i)) stage_d[i] = wr_data;
      end
    end
  end

  assign busy_d = dirty_d | (state_d != IDLE);

  // Commit FSM, staging bank and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      dirty_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      dirty_q <= dirty_d;
      busy_q  <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign dbg_state = state_q;

`else

  logic unused_commit_tick;

  assign stall              = 1'b0;
  assign unused_commit_tick = commit_tick;

  // Direct write into the active bank.
  always_comb begin
    active_d = active_q;
    if (wr_ok) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_addr == ADDR_W'(i)) active_d[i] = wr_data;
      end
    end
  end

  assign busy      = 1'b0;
  assign dbg_state = IDLE;

`endif

endmodule

// File: doc/cfg_write_arbiter.md
Name: cfg_write_arbiter

Overview:
- Sits between the SPI register-write front end and the rest of the chip; owns the 5-byte configuration bank (output enables lo/hi, PWM enables lo/hi, PWM duty cycle).
- Arbitrates write requests from two sources, round-robin: s0 = SPI frame decoder, already in clk domain; s1 = local sequencer/test master.
- Writes land in a staging bank. Staging is copied atomically to the active bank at a PWM period boundary (commit_tick), so consumers never see a half-updated configuration.

Parameters:
- NUM_REGS, 5, number of 8-bit config registers; valid addresses are 0..NUM_REGS-1.
- ADDR_W, 3, request address width.
- DATA_W, 8, register width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s0_valid  in  1  requester 0 write request.
- s0_addr  in  ADDR_W  requester 0 register address.
- s0_data  in  DATA_W  requester 0 write data.
- s0_ready  out  1  requester 0 transfer accepted this cycle (combinational).
- s1_valid, s1_addr, s1_data, s1_ready: same as s0, for requester 1.
- commit_tick  in  1  one-cycle pulse at PWM period boundary.
- reg_out  out  NUM_REGS*DATA_W  active bank; reg i at bits [i*8+7:i*8].
- busy  out  1  staging dirty or commit in progress.
- wr_err  out  1  one-cycle pulse: an out-of-range write was accepted last cycle.
- err_cnt  out  8  saturating count of out-of-range writes.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - reg_out, staging, err_cnt = 0; wr_err, busy = 0.
  - Commit FSM = IDLE; last_grant = 1, so s0 wins the first contention.
  - Reset mid-operation discards staged data and any pending commit immediately.
- Handshake:
  - A transfer occurs when sN_valid && sN_ready at the rising edge.
  - The requester holds valid/addr/data stable until ready.
  - At most one transfer per cycle.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not in last_grant.
  - last_grant updates only on an actual transfer.
  - sN_ready = grant_N && (state != COMMIT).
- Accepted write, addr < NUM_REGS:
  - staging[addr] <= data at that edge; dirty <= 1.
  - A later write to the same address overwrites (last-writer wins).
- Accepted write, addr >= NUM_REGS:
  - Data discarded; dirty unchanged.
  - wr_err = 1 for the following cycle.
  - err_cnt += 1, saturating at 255.
  - The request is still acknowledged, so a requester never hangs.
- Commit FSM, states IDLE, PENDING, COMMIT:
  - IDLE -> PENDING on the edge where dirty becomes 1.
  - PENDING -> COMMIT on an edge with commit_tick = 1.
  - COMMIT (exactly one cycle): both readys low; at its edge, active <= staging, dirty <= 0, state -> IDLE.
  - A write accepted in the same cycle as commit_tick is included in that commit.
  - commit_tick while IDLE (nothing dirty) is ignored.
  - commit_tick while in COMMIT is ignored.
- Latency:
  - Write to staging: 1 edge.
  - commit_tick to visible reg_out: 2 edges.
  - Worst-case stall for a requester: 1 COMMIT cycle plus 1 cycle lost to the other requester.
- busy = dirty || (state != IDLE), registered.

Optional Feature:
- Macro CFG_ARB_SHADOW_EN.
  - Defined: staging bank + commit FSM as above.
  - Undefined: no staging bank. Accepted in-range writes update reg_out directly at the accept edge; commit_tick ignored; FSM absent; busy tied 0; ready never stalled. Arbitration and error handling unchanged.

Decomposition:
- Package cfg_arb_pkg:
  - Commit FSM state enum (IDLE/PENDING/COMMIT).
  - NUM_REGS default and register index constants: REG_OUT_EN_LO=0, REG_OUT_EN_HI=1, REG_PWM_EN_LO=2, REG_PWM_EN_HI=3, REG_PWM_DUTY=4.
  - ERR_CNT_MAX = 255.
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: clk, rst_n, req[1:0], advance.
  - Output: grant[1:0], one-hot or zero.
  - Owns last_grant.

Test Plan:
- Reset, then s0 writes addr 4 = 8'h80, commit_tick 3 cycles later -> reg_out[39:32] stays 0 until 2 edges after tick, then 8'h80; busy 1 from the accept edge until the commit edge.
- s0 and s1 valid together for 4 cycles, addr 0 with data A1/B1 -> grants alternate s0, s1, s0, s1; staging[0] ends at s1's second value.
- s1 writes addr 6 = 8'hFF -> s1_ready=1, wr_err pulses next cycle, err_cnt=1, staging and dirty unchanged; 300 such writes -> err_cnt=255.
- s0 write accepted in the commit_tick cycle -> included in commit; in the COMMIT cycle both readys low and a pending s1 request is accepted the cycle after.
- commit_tick with nothing dirty -> FSM stays IDLE, reg_out unchanged.
- Assert rst_n=0 while in PENDING with staged data -> reg_out, busy, err_cnt = 0 immediately; a commit_tick after release commits nothing.
- Build with CFG_ARB_SHADOW_EN undefined -> write addr 2 = 8'h0F is visible on reg_out 1 edge after accept; commit_tick has no effect.
